ysyx_25060170_wb_arb: RTL
=========================

YSYX_25060170_WB_ARB -- requirements
Module: ysyx_25060170_wb_arb

Interface
REQ-001 SHALL have parameter DW, default 32, meaning GPR data width.
REQ-002 SHALL have parameter AW, default 5, meaning GPR address width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ex_valid input 1, ex_ready output 1, ex_waddr input AW, ex_wdata input DW: requester 0 (EXU result).
REQ-006 SHALL have ports ls_valid input 1, ls_ready output 1, ls_waddr input AW, ls_wdata input DW: requester 1 (LSU load result).
REQ-007 SHALL have ports gpr_wen output 1, gpr_waddr output AW, gpr_wdata output DW: the single GPR write port.
REQ-008 SHALL have ports issue_valid input 1, issue_rd input AW: destination register marked pending at issue.
REQ-009 SHALL have ports chk_rs1 input AW, chk_rs2 input AW, hazard output 1: RAW check for the instruction being decoded.
REQ-010 SHALL have port flush input 1: clears all pending marks.

Function
REQ-011 SHALL complete a transfer on a requester in any cycle where its valid and ready are both 1.
REQ-012 SHALL drive ex_ready/ls_ready combinationally; at most one is 1 per cycle; a ready is 1 only when its own valid is 1.
REQ-013 SHALL grant the sole valid requester when only one is valid.
REQ-014 SHALL, when both are valid, grant per a 1-bit priority register prio (0 = EX first, 1 = LS first).
REQ-015 SHALL, after every granted transfer, set prio to point at the non-granted requester (round-robin); prio is unchanged in idle cycles.
REQ-016 SHALL register the granted waddr/wdata; a transfer in cycle N drives gpr_wen=1 with that address/data in cycle N+1 only (latency 1, throughput 1/cycle).
REQ-017 SHALL hold gpr_wen=0 in any cycle following no transfer; gpr_waddr/gpr_wdata hold their last values.
REQ-018 SHALL accept a transfer with waddr==0 (handshake completes) but SHALL keep gpr_wen=0 for it.
REQ-019 SHALL keep a pending vector pend[31:0]; bit 0 is constant 0.
REQ-020 SHALL set pend[issue_rd] at the clock edge when issue_valid=1 and issue_rd!=0.
REQ-021 SHALL clear pend[waddr] of the granted transfer at the clock edge of the handshake cycle.
REQ-022 SHALL, on simultaneous set and clear of the same index, leave the bit set (new producer wins).
REQ-023 SHALL, when flush=1, clear every pend bit at the clock edge, overriding REQ-020/REQ-021; a transfer in the flush cycle still produces its gpr_wen in the next cycle.
REQ-024 SHALL drive hazard = (pend[chk_rs1] and chk_rs1!=0) or (pend[chk_rs2] and chk_rs2!=0), combinational from registered pend only.
REQ-025 SHALL rely on GPR write-through forwarding: a source cleared in cycle N reads correct data in cycle N+1 with hazard=0.

Reset
REQ-026 SHALL, while rst=0, force prio=0, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, pend=0 immediately, independent of clk.
REQ-027 SHALL hold ex_ready=ls_ready=0 and hazard=0 while rst=0.
REQ-028 SHALL, on reset assertion mid-transfer, drop the in-flight write (no gpr_wen after release until a new handshake).

Configuration
REQ-029 SHALL, with macro YSYX_25060170_SCOREBOARD_EN defined, implement REQ-019 to REQ-024 as stated.
REQ-030 SHALL, without YSYX_25060170_SCOREBOARD_EN, contain no pend storage, tie hazard to 0, and ignore issue_valid, issue_rd, chk_rs1, chk_rs2, flush; arbitration and write path are unchanged.

Verification
REQ-031 SHALL test: after reset both valid, ex_waddr=3/0x11, ls_waddr=4/0x22, held 2 cycles -> ex_ready first; gpr_wen with (3,0x11) then (4,0x22) on consecutive cycles.
REQ-032 SHALL test: only ls_valid for 3 cycles, waddr=5 -> ls_ready=1 every cycle, gpr_wen=1 for 3 consecutive cycles one cycle delayed, prio ends at 0.
REQ-033 SHALL test: ex_valid with ex_waddr=0, wdata=0xFFFF_FFFF -> ex_ready=1, next cycle gpr_wen=0.
REQ-034 SHALL test (SCOREBOARD_EN): issue_rd=7; next cycle chk_rs1=7 -> hazard=1; ex writes rd 7 -> hazard=0 the cycle after handshake.
REQ-035 SHALL test (SCOREBOARD_EN): issue_rd=9 and grant of waddr=9 in same cycle -> pend[9]=1; then flush=1 -> hazard for rs2=9 is 0 next cycle.
REQ-036 SHALL test: rst=0 asserted between clock edges during a handshake -> gpr_wen=0 immediately, no write after release.

Source files
------------

// File: rtl/ysyx_25060170_wb_arb.sv
// GPR write-back arbiter: two requesters (EXU, LSU) share the single GPR
// write port through a round-robin arbiter with a one-cycle registered
// write path. The optional RAW scoreboard (pending-destination vector and
// hazard output) is built only when YSYX_25060170_SCOREBOARD_EN is defined.
// Without it, hazard is tied to 0 and the issue/check/flush inputs are ignored.
module ysyx_25060170_wb_arb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [AW-1:0] ex_waddr,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ls_valid,
    output logic          ls_ready,
    input  logic [AW-1:0] ls_waddr,
    input  logic [DW-1:0] ls_wdata,
    output logic          gpr_wen,
    output logic [AW-1:0] gpr_waddr,
    output logic [DW-1:0] gpr_wdata,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    output logic          hazard,
    input  logic          flush
);

    localparam int NR = 1 << AW;

    logic          w_gnt_ex;
    logic          w_gnt_ls;
    logic          w_xfer;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    logic          r_prio;
    logic          r_wen;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;

    // Grant: a lone valid requester wins; on contention r_prio decides.
    // Readies are held low during reset.
    always_comb begin
        w_gnt_ex = rst & ex_valid & (~ls_valid | ~r_prio);
        w_gnt_ls = rst & ls_valid & (~ex_valid | r_prio);
        w_xfer   = w_gnt_ex | w_gnt_ls;
        w_waddr  = w_gnt_ls ? ls_waddr : ex_waddr;
        w_wdata  = w_gnt_ls ? ls_wdata : ex_wdata;
    end

    assign ex_ready = w_gnt_ex;
    assign ls_ready = w_gnt_ls;

    // Round-robin pointer: after a grant, point at the requester that lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (w_xfer) begin
            r_prio <= w_gnt_ex;
        end
    end

    // Write path: register the granted transfer; writes to x0 complete the
    // handshake but never raise the write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_xfer && (w_waddr != '0);
            if (w_xfer) begin
                r_waddr <= w_waddr;
                r_wdata <= w_wdata;
            end
        end
    end

    assign gpr_wen   = r_wen;
    assign gpr_waddr = r_waddr;
    assign gpr_wdata = r_wdata;

`ifdef YSYX_25060170_SCOREBOARD_EN
    logic [NR-1:0] r_pend;
    logic [NR-1:0] w_pend_nxt;

    // Pending update: clear on write-back grant, then set on issue so a new
    // producer of the same register wins; flush overrides everything.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_xfer) begin
            w_pend_nxt[w_waddr] = 1'b0;
        end
        if (issue_valid) begin
            w_pend_nxt[issue_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
        if (flush) begin
            w_pend_nxt = '0;
        end
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign hazard = rst & ((r_pend[chk_rs1] & (chk_rs1 != '0)) |
                           (r_pend[chk_rs2] & (chk_rs2 != '0)));
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{issue_valid, issue_rd, chk_rs1, chk_rs2, flush};
    assign hazard      = 1'b0;
`endif

endmodule
